// File: rtl/sseg_readback_if.sv
// Bus bundle for sseg_readback: request, raw segment inputs and the decoded capture result.
interface sseg_readback_if;
    logic        req;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic [6:0]  HEX5;
    logic [15:0] value;
    logic [3:0]  bad;
    logic        valid;
    logic        done;
    logic        timeout;
    logic        busy;
    logic        Z;
    logic        N;
    logic        V;

    modport master (
        output req, HEX0, HEX1, HEX2, HEX3, HEX5,
        input  value, bad, valid, done, timeout, busy, Z, N, V
    );

    modport slave (
        input  req, HEX0, HEX1, HEX2, HEX3, HEX5,
        output value, bad, valid, done, timeout, busy, Z, N, V
    );
endinterface

// File: rtl/sseg_readback.sv
// Recovers the 16-bit value shown on HEX3..HEX0 once the segments have settled.
// Optional status-flag capture from HEX5 is enabled by defining SSEG_READBACK_FLAGS_EN.

// One active-low 7-segment glyph to nibble; unknown patterns decode to 0 and flag bad.
module sseg_digit_dec (
    input  logic [6:0] seg,
    output logic [3:0] nib,
    output logic       bad
);
    always_comb begin
        nib = 4'h0;
        bad = 1'b0;
        case (seg)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            default:    bad = 1'b1;
        endcase
    end
endmodule

module sseg_readback #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic           clk,
    input  logic           reset,
    sseg_readback_if.slave bus
);
    localparam int NUM_LANES = 4;
    localparam int SEG_W     = 7;
`ifdef SSEG_READBACK_FLAGS_EN
    localparam int SNAP_W = 5 * SEG_W;
`else
    localparam int SNAP_W = NUM_LANES * SEG_W;
`endif

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15) begin : g_bad_stable
        $error("sseg_readback: STABLE_CYCLES out of range 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255 || TIMEOUT < STABLE_CYCLES) begin : g_bad_timeout
        $error("sseg_readback: TIMEOUT out of range or below STABLE_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t                            state, state_nx;
    logic [SNAP_W-1:0]                 snap, sample;
    logic [3:0]                        scnt;
    logic [7:0]                        tcnt;
    logic [NUM_LANES-1:0][3:0]         nib;
    logic [NUM_LANES-1:0]              nib_bad;
    logic [15:0]                       value_q;
    logic [3:0]                        bad_q;
    logic                              valid_q, timeout_q;
    logic                              busy_c, done_c;
    logic                              stable_hit, tmo_hit;

`ifdef SSEG_READBACK_FLAGS_EN
    assign sample = {bus.HEX5, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
`else
    logic unused_hex5;
    assign unused_hex5 = ^bus.HEX5;
    assign sample      = {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
`endif

    // Decode always works off the snapshot, which equals the inputs whenever the decode fires.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sseg_digit_dec u_dec (
            .seg (snap[SEG_W*i +: SEG_W]),
            .nib (nib[i]),
            .bad (nib_bad[i])
        );
    end

    assign stable_hit = (scnt == 4'(STABLE_CYCLES));
    assign tmo_hit    = (tcnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE:    if (bus.req) state_nx = SETTLE;
            SETTLE: begin
                busy_c = 1'b1;
                if (stable_hit || tmo_hit) state_nx = DONE;
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap      <= '0;
            scnt      <= '0;
            tcnt      <= '0;
            value_q   <= '0;
            bad_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req) begin
                    snap      <= sample;
                    scnt      <= 4'd1;
                    tcnt      <= 8'd0;
                    valid_q   <= 1'b0;
                    timeout_q <= 1'b0;
                end
                SETTLE: begin
                    if (stable_hit) begin
                        value_q <= nib;
                        bad_q   <= nib_bad;
                        valid_q <= ~|nib_bad;
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        // Any change restarts the stability run from the new pattern.
                        if (sample == snap) begin
                            scnt <= scnt + 4'd1;
                        end else begin
                            snap <= sample;
                            scnt <= 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SSEG_READBACK_FLAGS_EN
    logic z_q, n_q, v_q;

    // HEX5 sits in snap[34:28]; flags are lit-segment (active-low) indicators.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (state == SETTLE && stable_hit) begin
            z_q <= ~snap[4*SEG_W + 0];
            n_q <= ~snap[4*SEG_W + 6];
            v_q <= ~snap[4*SEG_W + 3];
        end
    end

    assign bus.Z = z_q;
    assign bus.N = n_q;
    assign bus.V = v_q;
`else
    assign bus.Z = 1'b0;
    assign bus.N = 1'b0;
    assign bus.V = 1'b0;
`endif

    assign bus.value   = value_q;
    assign bus.bad     = bad_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;
    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
endmodule
